// File: rtl/pool_result_writer.sv
// Pool result writer: packs the pooled-value strobe stream into PACK-lane
// memory words, zero-pads each row end, assigns linear output addresses and
// writes through a small skid FIFO to the feature-map SRAM.
// Optional fused ReLU is enabled by defining POOL_WRITER_RELU_EN.
module pool_result_writer #(
  parameter int DATA_W     = 16,
  parameter int OUT_DIM    = 14,
  parameter int PACK       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   pool_done,
  input  logic [DATA_W-1:0]      pool_data,
  input  logic                   pooling_finish,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [PACK*DATA_W-1:0] mem_wdata,
  input  logic                   mem_ready,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   count_err
);

  localparam int WPR        = (OUT_DIM + PACK - 1) / PACK;
  localparam int TOTAL      = OUT_DIM * WPR;
  localparam int TOTAL_VALS = OUT_DIM * OUT_DIM;
  localparam int WORD_W     = PACK * DATA_W;
  localparam int LANE_W     = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int COL_W      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int VAL_W      = $clog2(TOTAL_VALS + 3);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(PACK - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(OUT_DIM - 1);
  localparam logic [VAL_W-1:0]  VAL_TARGET = VAL_W'(TOTAL_VALS);
  localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  // The address counter must reach the last word of the frame without wrapping
  if (BASE_ADDR + TOTAL - 1 >= (1 << ADDR_W)) begin : g_addr_check
    $error("pool_result_writer: ADDR_W too small for BASE_ADDR + TOTAL - 1");
  end
  if (FIFO_DEPTH < 2 || (1 << PTR_W) != FIFO_DEPTH) begin : g_fifo_check
    $error("pool_result_writer: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t                   state_q, state_d;
  logic [WORD_W-1:0]        pack_q, pack_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [COL_W-1:0]         row_q, row_d;
  logic [VAL_W-1:0]         val_q, val_d;
  logic [ADDR_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [WORD_W-1:0]        fifo_mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0]        fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic                     overflow_q, overflow_d;
  logic                     count_err_q, count_err_d;

  logic [DATA_W-1:0]        val_in;
  logic [WORD_W-1:0]        fill_word;
  logic [VAL_W-1:0]         val_total;
  logic                     restart, accept, finish, row_end;
  logic                     push, pop, full, do_push;

  // Input value conditioning: optional clamp of negative values to zero
  always_comb begin
`ifdef POOL_WRITER_RELU_EN
    val_in = pool_data[DATA_W-1] ? '0 : pool_data;
`else
    val_in = pool_data;
`endif
  end

  // Word assembly and FIFO handshake decode
  always_comb begin
    restart = start && (state_q != DONE);
    accept  = (state_q == COLLECT) && pool_done && !start;
    finish  = (state_q == COLLECT) && pooling_finish && !start;
    row_end = (col_q == COL_LAST);
    fill_word = pack_q;
    for (int i = 0; i < PACK; i++) begin
      if (accept && lane_q == LANE_W'(i)) fill_word[i*DATA_W +: DATA_W] = val_in;
    end
    push      = (accept && (lane_q == LANE_LAST || row_end)) ||
                (finish && (accept || lane_q != '0));
    pop       = (fifo_cnt_q != '0) && mem_ready;
    full      = (fifo_cnt_q == FIFO_FULL);
    do_push   = push && (!full || pop);
    val_total = val_q + VAL_W'(accept);
  end

  // Next-state logic for the frame controller
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (!start && pooling_finish) state_d = FLUSH;
      FLUSH:   if (start) state_d = COLLECT;
               else if (fifo_cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter, pack register, FIFO and sticky-flag updates
  always_comb begin
    pack_d      = pack_q;
    lane_d      = lane_q;
    col_d       = col_q;
    row_d       = row_q;
    val_d       = val_q;
    wr_cnt_d    = wr_cnt_q;
    fifo_mem_d  = fifo_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    overflow_d  = overflow_q;
    count_err_d = count_err_q;
    if (restart) begin
      pack_d      = '0;
      lane_d      = '0;
      col_d       = '0;
      row_d       = '0;
      val_d       = '0;
      wr_cnt_d    = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      fifo_cnt_d  = '0;
      overflow_d  = 1'b0;
      count_err_d = 1'b0;
    end else begin
      if (accept) begin
        pack_d = fill_word;
        lane_d = lane_q + 1'b1;
        col_d  = col_q + 1'b1;
        if (val_q <= VAL_TARGET) val_d = val_q + 1'b1;
        if (row_end) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end
      end
      if (push) begin
        pack_d = '0;
        lane_d = '0;
      end
      if (finish && val_total != VAL_TARGET) count_err_d = 1'b1;
      if (do_push) begin
        fifo_mem_d[wr_ptr_q] = fill_word;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (push && !do_push) overflow_d = 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
      fifo_cnt_d = fifo_cnt_q + CNT_W'(do_push) - CNT_W'(pop);
    end
  end

  // Frame controller state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pack_q      <= '0;
      lane_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      val_q       <= '0;
      wr_cnt_q    <= '0;
      fifo_mem_q  <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      count_err_q <= 1'b0;
    end else begin
      pack_q      <= pack_d;
      lane_q      <= lane_d;
      col_q       <= col_d;
      row_q       <= row_d;
      val_q       <= val_d;
      wr_cnt_q    <= wr_cnt_d;
      fifo_mem_q  <= fifo_mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      overflow_q  <= overflow_d;
      count_err_q <= count_err_d;
    end
  end

  // Status and memory-write outputs
  always_comb begin
    busy       = (state_q == COLLECT) || (state_q == FLUSH);
    frame_done = (state_q == DONE);
    mem_we     = (fifo_cnt_q != '0);
    mem_wdata  = fifo_mem_q[rd_ptr_q];
    mem_addr   = BASE + wr_cnt_q;
    overflow   = overflow_q;
    count_err  = count_err_q;
  end

endmodule

// File: tb/tb_pool_result_writer.sv
// Testbench for pool_result_writer: directed frames on a 14x14 instance and a
// 3x3 instance, with expected memory writes queued by the stimulus and
// checked by per-instance write monitors.
module tb_pool_result_writer;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;

  logic        start, pool_done, pooling_finish, mem_ready;
  logic [15:0] pool_data;
  logic        mem_we, busy, frame_done, overflow, count_err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  logic        start3, pool_done3, pooling_finish3, mem_ready3;
  logic [15:0] pool_data3;
  logic        mem_we3, busy3, frame_done3, overflow3, count_err3;
  logic [7:0]  mem_addr3;
  logic [31:0] mem_wdata3;

  exp_t q14[$];
  exp_t q3[$];
  int   checks = 0;
  int   failures = 0;
  int   fd_cnt14 = 0;
  int   fd_cnt3 = 0;
  int   prev_fd;

  logic [31:0] exp3 [6];

  always #5 clk = ~clk;

  pool_result_writer #(
    .DATA_W(16), .OUT_DIM(14), .PACK(2), .FIFO_DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)
  ) u_dut14 (
    .clk(clk), .nrst(nrst), .start(start), .pool_done(pool_done),
    .pool_data(pool_data), .pooling_finish(pooling_finish), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .count_err(count_err)
  );

  pool_result_writer #(
    .DATA_W(16), .OUT_DIM(3), .PACK(2), .FIFO_DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)
  ) u_dut3 (
    .clk(clk), .nrst(nrst), .start(start3), .pool_done(pool_done3),
    .pool_data(pool_data3), .pooling_finish(pooling_finish3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_ready(mem_ready3),
    .busy(busy3), .frame_done(frame_done3), .overflow(overflow3), .count_err(count_err3)
  );

  // Compare one value and log a failure line on mismatch
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Write monitor for the 14x14 instance: every accepted write must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (nrst && frame_done) fd_cnt14++;
    if (nrst && mem_we && mem_ready) begin
      if (q14.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wr14_unexpected: actual addr=%0h data=%0h required=no write",
                 mem_addr, mem_wdata);
      end else begin
        e = q14.pop_front();
        check_output("wr14_addr", 32'(mem_addr), 32'(e.addr));
        check_output("wr14_data", mem_wdata, e.data);
      end
    end
  end

  // Write monitor for the 3x3 instance
  always @(negedge clk) begin
    exp_t e;
    if (nrst && frame_done3) fd_cnt3++;
    if (nrst && mem_we3 && mem_ready3) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wr3_unexpected: actual addr=%0h data=%0h required=no write",
                 mem_addr3, mem_wdata3);
      end else begin
        e = q3.pop_front();
        check_output("wr3_addr", 32'(mem_addr3), 32'(e.addr));
        check_output("wr3_data", mem_wdata3, e.data);
      end
    end
  end

  // One pooled value on the 14x14 instance followed by an idle cycle
  task automatic apply_stimulus(input logic [15:0] data, input logic fin);
    @(posedge clk); #1;
    pool_done = 1'b1;
    pool_data = data;
    pooling_finish = fin;
    @(posedge clk); #1;
    pool_done = 1'b0;
    pooling_finish = 1'b0;
  endtask

  task automatic apply_stimulus3(input logic [15:0] data, input logic fin);
    @(posedge clk); #1;
    pool_done3 = 1'b1;
    pool_data3 = data;
    pooling_finish3 = fin;
    @(posedge clk); #1;
    pool_done3 = 1'b0;
    pooling_finish3 = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Values 0..n-1; odd values close a word {v, v-1}; an odd count ends with {0, n-1}
  task automatic send_frame(input int n, input logic last_fin, input logic with_exp);
    for (int v = 0; v < n; v++) begin
      if (with_exp && (v % 2 == 1)) q14.push_back('{addr: 8'(v / 2), data: {16'(v), 16'(v - 1)}});
      if (with_exp && last_fin && (v == n - 1) && (n % 2 == 1))
        q14.push_back('{addr: 8'(n / 2), data: {16'h0000, 16'(n - 1)}});
      apply_stimulus(16'(v), last_fin && (v == n - 1));
    end
  endtask

  task automatic wait_fd14(input int prev, input string name);
    int n = 0;
    while (fd_cnt14 == prev && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fd_cnt14 == prev) begin
      failures++;
      $display("[TB] FAIL %s: frame_done not seen within 2000 cycles, required a pulse", name);
    end
  endtask

  task automatic wait_drain14(input string name);
    int n = 0;
    while (q14.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(q14.size()), 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0; pool_done = 1'b0; pool_data = '0; pooling_finish = 1'b0; mem_ready = 1'b1;
    start3 = 1'b0; pool_done3 = 1'b0; pool_data3 = '0; pooling_finish3 = 1'b0; mem_ready3 = 1'b1;
    exp3 = '{32'h0002_0001, 32'h0000_0003, 32'h0005_0004,
             32'h0000_0006, 32'h0008_0007, 32'h0000_0009};

    // Reset state
    #12;
    check_output("reset_flags14", 32'({mem_we, busy, frame_done, overflow, count_err}), 32'd0);
    check_output("reset_addr14", 32'(mem_addr), 32'd0);
    check_output("reset_wdata14", mem_wdata, 32'd0);
    check_output("reset_flags3", 32'({mem_we3, busy3, frame_done3, overflow3, count_err3}), 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Row padding on the 3x3 instance
    @(posedge clk); #1; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    for (int i = 0; i < 6; i++) q3.push_back('{addr: 8'(i), data: exp3[i]});
    for (int v = 1; v <= 9; v++) apply_stimulus3(16'(v), v == 9);
    for (int n = 0; n < 200 && fd_cnt3 == 0; n++) @(negedge clk);
    check_output("pad3_frame_done", 32'(fd_cnt3), 32'd1);
    check_output("pad3_queue_empty", 32'(q3.size()), 32'd0);
    check_output("pad3_flags", 32'({count_err3, overflow3}), 32'd0);

    // Base stream: full 196-value frame
    prev_fd = fd_cnt14;
    pulse_start();
    check_output("base_busy", 32'(busy), 32'd1);
    send_frame(196, 1'b1, 1'b1);
    wait_fd14(prev_fd, "base_frame_done");
    check_output("base_writes_before_done", 32'(q14.size()), 32'd0);
    repeat (4) @(negedge clk);
    check_output("base_single_done", 32'(fd_cnt14 - prev_fd), 32'd1);
    check_output("base_flags", 32'({count_err, overflow, busy}), 32'd0);

    // Backpressure: four words held, fifth dropped
    mem_ready = 1'b0;
    pulse_start();
    for (int v = 0; v < 10; v++) begin
      if (v % 2 == 1 && v < 9) q14.push_back('{addr: 8'(v / 2), data: {16'(v), 16'(v - 1)}});
      apply_stimulus(16'(v), 1'b0);
    end
    check_output("bp_overflow", 32'(overflow), 32'd1);
    check_output("bp_we", 32'(mem_we), 32'd1);
    check_output("bp_addr", 32'(mem_addr), 32'd0);
    check_output("bp_wdata", mem_wdata, 32'h0001_0000);
    repeat (5) @(posedge clk);
    #1;
    check_output("bp_addr_hold", 32'(mem_addr), 32'd0);
    check_output("bp_wdata_hold", mem_wdata, 32'h0001_0000);
    mem_ready = 1'b1;
    wait_drain14("bp_drain");
    @(posedge clk); #1;
    check_output("bp_we_idle", 32'(mem_we), 32'd0);
    check_output("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Early finish on the 11th value (aborts the stalled frame first)
    prev_fd = fd_cnt14;
    pulse_start();
    check_output("early_overflow_cleared", 32'(overflow), 32'd0);
    send_frame(11, 1'b1, 1'b1);
    wait_fd14(prev_fd, "early_frame_done");
    check_output("early_queue_empty", 32'(q14.size()), 32'd0);
    check_output("early_count_err", 32'(count_err), 32'd1);

    // Abort after 20 values, then a full frame
    repeat (3) @(posedge clk);
    prev_fd = fd_cnt14;
    pulse_start();
    check_output("abort_count_err_cleared", 32'(count_err), 32'd0);
    send_frame(20, 1'b0, 1'b1);
    wait_drain14("abort_partial_drain");
    repeat (2) @(posedge clk);
    pulse_start();
    send_frame(196, 1'b1, 1'b1);
    wait_fd14(prev_fd, "abort_frame_done");
    repeat (20) @(negedge clk);
    check_output("abort_single_done", 32'(fd_cnt14 - prev_fd), 32'd1);
    check_output("abort_queue_empty", 32'(q14.size()), 32'd0);
    check_output("abort_count_err", 32'(count_err), 32'd0);

    // Asynchronous reset mid-frame with words pending
    mem_ready = 1'b0;
    pulse_start();
    send_frame(4, 1'b0, 1'b0);
    check_output("rst_pre_we", 32'(mem_we), 32'd1);
    @(posedge clk); #3;
    nrst = 1'b0;
    #1;
    check_output("rst_flags", 32'({mem_we, busy, frame_done, overflow, count_err}), 32'd0);
    check_output("rst_addr", 32'(mem_addr), 32'd0);
    check_output("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    mem_ready = 1'b1;

    // Sign handling: -5 then 7 in one word
    prev_fd = fd_cnt14;
    pulse_start();
`ifdef POOL_WRITER_RELU_EN
    q14.push_back('{addr: 8'd0, data: 32'h0007_0000});
`else
    q14.push_back('{addr: 8'd0, data: 32'h0007_FFFB});
`endif
    apply_stimulus(16'hFFFB, 1'b0);
    apply_stimulus(16'h0007, 1'b1);
    wait_fd14(prev_fd, "relu_frame_done");
    check_output("relu_queue_empty", 32'(q14.size()), 32'd0);
    check_output("relu_count_err", 32'(count_err), 32'd1);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
